// File: rtl/xilinx_board_status_leds.sv
// xilinx_board_status_leds: per-channel LED modes, sticky exit pass/fail indicator and stretched reset LED
module xilinx_board_status_leds #(
  parameter int NUM_LEDS             = 4,
  parameter int CLK_LED_COUNT_LENGTH = 27,
  parameter int PWM_WIDTH            = 8,
  parameter int RST_STRETCH_CYCLES   = 1000000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [2*NUM_LEDS-1:0]         mode_i,
  input  logic [PWM_WIDTH*NUM_LEDS-1:0] duty_i,
  input  logic                          exit_valid_i,
  input  logic [31:0]                   exit_value_i,
  input  logic                          exit_clear_i,
  output logic [NUM_LEDS-1:0]           led_o,
  output logic                          exit_led_o,
  output logic [1:0]                    exit_state_o,
  output logic                          rst_led_o
);
  localparam int SW = $clog2(RST_STRETCH_CYCLES + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, PASS = 2'b01, FAIL = 2'b10} state_t;
  state_t state, state_nxt;
  logic [CLK_LED_COUNT_LENGTH-1:0] hb_cnt;
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [SW-1:0] stretch_cnt;
  logic [NUM_LEDS-1:0] led_nxt;
  logic hb, fast;
  assign hb = hb_cnt[CLK_LED_COUNT_LENGTH-1];
  assign fast = hb_cnt[CLK_LED_COUNT_LENGTH-4];
  assign exit_state_o = state;
  for (genvar k = 0; k < NUM_LEDS; k++) begin : g_ch
    assign led_nxt[k] = (mode_i[2*k+:2] == 2'b00) ? 1'b0 :
                        (mode_i[2*k+:2] == 2'b01) ? 1'b1 :
                        (mode_i[2*k+:2] == 2'b10) ? hb :
                        (pwm_cnt < duty_i[PWM_WIDTH*k+:PWM_WIDTH]);
  end
  // exit status: clear wins, valid only samples while idle so the result is sticky
  always_comb begin
    state_nxt = exit_clear_i ? IDLE :
                (state == IDLE && exit_valid_i) ? ((exit_value_i == 32'd0) ? PASS : FAIL) :
                state;
  end
  // counters, registered LED drive, exit state and reset stretch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hb_cnt      <= '0;
      pwm_cnt     <= '0;
      led_o       <= '0;
      exit_led_o  <= 1'b0;
      state       <= IDLE;
      stretch_cnt <= SW'(RST_STRETCH_CYCLES);
      rst_led_o   <= 1'b1;
    end else begin
      hb_cnt      <= hb_cnt + CLK_LED_COUNT_LENGTH'(1);
      pwm_cnt     <= pwm_cnt + PWM_WIDTH'(1);
      led_o       <= led_nxt;
      state       <= state_nxt;
      exit_led_o  <= (state_nxt == PASS) | ((state_nxt == FAIL) & fast);
      stretch_cnt <= (stretch_cnt != '0) ? stretch_cnt - SW'(1) : '0;
      rst_led_o   <= (stretch_cnt != '0);
    end
  end
endmodule

// File: tb/tb_xilinx_board_status_leds.sv
// tb_xilinx_board_status_leds: cycle-level model comparison plus directed literal checks
module tb_xilinx_board_status_leds;
  logic clk = 1'b0, rst;
  logic [3:0] mode;
  logic [5:0] duty;
  logic valid, clear;
  logic [31:0] value;
  logic [1:0] led_o, exit_state_o;
  logic exit_led_o, rst_led_o;
  int errors = 0, checks = 0;
  int n = 0;
  bit live = 0;
  logic [1:0] m_led;
  int m_state;
  bit m_xled, m_rled;
  int ones0, ones1;

  xilinx_board_status_leds #(
    .NUM_LEDS(2), .CLK_LED_COUNT_LENGTH(6), .PWM_WIDTH(3), .RST_STRETCH_CYCLES(5)
  ) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .duty_i(duty),
    .exit_valid_i(valid), .exit_value_i(value), .exit_clear_i(clear),
    .led_o(led_o), .exit_led_o(exit_led_o), .exit_state_o(exit_state_o), .rst_led_o(rst_led_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // n = non-reset edges seen since release, i.e. the counter value before this edge
  always @(posedge clk) begin
    if (rst) begin
      n = 0; m_led = 2'b00; m_state = 0; m_xled = 0; m_rled = 1; live = 1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        int md, dk;
        md = (mode >> (2 * k)) & 3;
        dk = (duty >> (3 * k)) & 7;
        m_led[k] = (md == 0) ? 1'b0 : (md == 1) ? 1'b1 :
                   (md == 2) ? (((n / 32) % 2) == 1) : ((n % 8) < dk);
      end
      if (clear) m_state = 0;
      else if (m_state == 0 && valid) m_state = (value == 0) ? 1 : 2;
      m_xled = (m_state == 1) || (m_state == 2 && ((n / 4) % 2) == 1);
      m_rled = (n < 5);
      n++;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("model led_o", led_o, m_led);
      chk("model exit_state_o", exit_state_o, m_state);
      chk("model exit_led_o", exit_led_o, m_xled);
      chk("model rst_led_o", rst_led_o, m_rled);
    end
  end

  initial begin
    rst = 1; mode = 4'b0000; duty = 6'd0; valid = 0; clear = 0; value = 32'd0;
    repeat (3) tick();
    chk("reset led_o", led_o, 0);
    chk("reset exit_state", exit_state_o, 0);
    chk("reset rst_led", rst_led_o, 1);
    mode = 4'b1001; rst = 0;
    tick();
    chk("ch0 on after release", led_o[0], 1);
    chk("stretch E1", rst_led_o, 1);
    repeat (4) tick();
    chk("stretch E5", rst_led_o, 1);
    tick();
    chk("stretch E6", rst_led_o, 0);
    repeat (26) tick();
    chk("hb E32", led_o[1], 0);
    tick();
    chk("hb E33", led_o[1], 1);
    repeat (31) tick();
    chk("hb E64", led_o[1], 1);
    tick();
    chk("hb E65", led_o[1], 0);
    mode = 4'b1111; duty = 6'b000_011;
    tick();
    ones0 = 0; ones1 = 0;
    repeat (8) begin tick(); ones0 += led_o[0]; ones1 += led_o[1]; end
    chk("pwm duty3 ones", ones0, 3);
    chk("pwm duty0 ones", ones1, 0);
    duty = 6'b000_111;
    tick();
    ones0 = 0;
    repeat (8) begin tick(); ones0 += led_o[0]; end
    chk("pwm duty7 ones", ones0, 7);
    valid = 1; value = 32'd0;
    tick();
    valid = 0;
    chk("pass state", exit_state_o, 1);
    chk("pass led", exit_led_o, 1);
    valid = 1; value = 32'd5;
    tick();
    valid = 0;
    chk("pass sticky", exit_state_o, 1);
    clear = 1;
    tick();
    clear = 0;
    chk("clear state", exit_state_o, 0);
    chk("clear led", exit_led_o, 0);
    valid = 1; value = 32'd2;
    tick();
    valid = 0;
    chk("fail bit1", exit_state_o, 2);
    clear = 1;
    tick();
    clear = 0;
    valid = 1; value = 32'h8000_0000;
    tick();
    valid = 0;
    chk("fail msb", exit_state_o, 2);
    ones0 = 0;
    repeat (8) begin tick(); ones0 += exit_led_o; end
    chk("fail blink ones", ones0, 4);
    clear = 1; valid = 1; value = 32'd0;
    tick();
    clear = 0; valid = 0;
    chk("clear beats valid", exit_state_o, 0);
    valid = 1; value = 32'd1;
    tick();
    valid = 0;
    chk("fail again", exit_state_o, 2);
    rst = 1;
    tick();
    chk("midreset led_o", led_o, 0);
    chk("midreset state", exit_state_o, 0);
    chk("midreset exit_led", exit_led_o, 0);
    chk("midreset rst_led", rst_led_o, 1);
    rst = 0;
    tick();
    chk("restretch E1", rst_led_o, 1);
    repeat (4) tick();
    chk("restretch E5", rst_led_o, 1);
    tick();
    chk("restretch E6", rst_led_o, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
